syscall_ctrl: RTL
=================

// Module: syscall_ctrl
// PURPOSE
//  Sequences MIPS syscall service at the WB stage. Replaces the WB-local clock
//  gating and display latch with one controller.
//  Services print-style syscalls by latching $a0 to the display and stalling
//  the pipeline for a minimum hold time, with optional operator acknowledge.
//  Services exit (v0 == HALT_CODE) by dropping the pipeline run enable
//  permanently. Sits between WB and the IF..MEM stage enables.
// PARAMETERS
//  HOLD_CYCLES  4             cycles a print stalls the pipeline; legal >= 1
//  WAIT_RESUME  0             1: print also waits for a resume pulse after hold
//  HALT_CODE    32'h0000_000a $v0 value meaning exit/halt
// PORTS
//  Clock       in   1   system clock; all state on rising edge
//  Resetn      in   1   asynchronous, active-low reset
//  sc_valid    in   1   syscall instruction is in WB this cycle
//  sc_v0       in   32  $v0 value forwarded to WB
//  sc_a0       in   32  $a0 value forwarded to WB
//  resume      in   1   operator acknowledge, 1-cycle pulse, synchronous
//  run_en      out  1   pipeline clock enable; 0 = frozen
//  stall       out  1   freeze IF..MEM and hold WB inputs
//  display     out  32  last printed $a0
//  disp_valid  out  1   display holds a printed value
//  halted      out  1   program has executed exit
//  sc_count    out  16  syscalls accepted, saturating
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, display=0, disp_valid=0, halted=0, sc_count=0, hold counter=0.
//   - run_en=1 and stall=0 while Resetn is low.
//  States: IDLE, SHOW, HALT (2-bit register).
//  Accept event:
//   - Occurs when sc_valid=1 in IDLE. sc_valid outside IDLE is ignored.
//   - Stall already freezes WB, so sc_valid outside IDLE is a bench assertion
//     error, not a design case.
//  IDLE, sc_valid, sc_v0 == HALT_CODE:
//   - Next state HALT; halted<=1; sc_count++.
//  IDLE, sc_valid, sc_v0 != HALT_CODE:
//   - display<=sc_a0; disp_valid<=1; hold<=HOLD_CYCLES-1; sc_count++.
//   - Next state SHOW.
//  SHOW:
//   - hold decrements each cycle while nonzero.
//   - WAIT_RESUME=0: leave to IDLE in the cycle after hold reaches 0.
//   - WAIT_RESUME=1: leave to IDLE on the first cycle with hold==0 and resume=1.
//     A resume that arrives while hold is nonzero is dropped, not latched.
//  HALT: terminal. Only Resetn leaves HALT; resume is ignored.
//  Combinational outputs (zero latency, so the syscall's successors never
//  advance):
//   - stall  = (state != IDLE) | (state == IDLE & sc_valid)
//   - run_en = ~((state == HALT) | (state == IDLE & sc_valid & sc_v0 == HALT_CODE))
//  Timing:
//   - A print holds stall for exactly HOLD_CYCLES+1 cycles: the accept cycle
//     plus HOLD_CYCLES cycles in SHOW (WAIT_RESUME=0).
//   - Example: HOLD_CYCLES=1 gives accept cycle + one SHOW cycle, then IDLE.
//  Registered outputs:
//   - display, disp_valid and halted change one edge after accept.
//   - display holds its value through later IDLE periods and through HALT.
//  sc_count saturates at 16'hFFFF and never wraps.
//  Simultaneous events:
//   - resume together with sc_valid in IDLE: the syscall is serviced, resume
//     is ignored.
//   - Exit while a value is displayed: display is kept.
//  Compare width: sc_v0 is compared against HALT_CODE over the full 32 bits.
//  Reset mid-SHOW or mid-HALT: all state returns to reset values immediately
//  (asynchronous), and run_en returns to 1.
// TESTING
//  T1 Reset: Resetn=0, random inputs -> run_en=1, stall=0, display=0,
//     sc_count=0, halted=0.
//  T2 Print, HOLD_CYCLES=4, WAIT_RESUME=0, sc_v0=1, sc_a0=32'h0000_002a:
//     - stall high exactly 5 cycles; display=0x2a from the next edge.
//     - sc_count=1; back in IDLE.
//  T3 WAIT_RESUME=1, print 0xdead_beef:
//     - resume pulse at hold=2 is ignored.
//     - resume pulse 3 cycles later -> IDLE the next edge; stall deasserts.
//  T4 Exit, sc_v0=32'h0000_000a after a print of 7:
//     - run_en=0 in the accept cycle and for ever after; halted=1; display=7.
//     - resume pulses have no effect.
//  T5 Reset mid-SHOW (2nd hold cycle): async drop of Resetn -> outputs at reset
//     values before the next edge.
//  T6 Saturation: preload by 65 535 accepted prints (HOLD_CYCLES=1), then 2
//     more -> sc_count stays 16'hFFFF.

Source files
------------

// File: rtl/syscall_ctrl.sv
// ============================================================================
// Module   : syscall_ctrl
// Brief    : WB-stage syscall sequencer: print display/hold stall and exit halt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module syscall_ctrl #(
    parameter int          HOLD_CYCLES  = 4,
    parameter bit          WAIT_RESUME  = 1'b0,
    parameter logic [31:0] HALT_CODE    = 32'h0000_000a,
    parameter logic [15:0] SC_COUNT_RST = 16'h0000
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        sc_valid,
    input  logic [31:0] sc_v0,
    input  logic [31:0] sc_a0,
    input  logic        resume,
    output logic        run_en,
    output logic        stall,
    output logic [31:0] display,
    output logic        disp_valid,
    output logic        halted,
    output logic [15:0] sc_count
);

    localparam int              HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [15:0]     CNT_MAX   = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SHOW = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [HOLD_W-1:0]   r_hold;
    logic [31:0]         r_display;
    logic                r_disp_valid;
    logic                r_halted;
    logic [15:0]         r_count;

    logic w_accept;
    logic w_is_exit;
    logic w_hold_zero;
    logic w_stall;
    logic w_run_en;

    assign w_accept    = (r_state == S_IDLE) && sc_valid;
    assign w_is_exit   = (sc_v0 == HALT_CODE);
    assign w_hold_zero = (r_hold == '0);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Stall and run enable are combinational so the syscall's successors never advance.
    always_comb begin
        w_next   = r_state;
        w_stall  = 1'b0;
        w_run_en = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (sc_valid) begin
                    w_stall = 1'b1;
                    if (w_is_exit) begin
                        w_run_en = 1'b0;
                        w_next   = S_HALT;
                    end else begin
                        w_next   = S_SHOW;
                    end
                end
            end
            S_SHOW: begin
                w_stall = 1'b1;
                if (w_hold_zero && (!WAIT_RESUME || resume)) begin
                    w_next = S_IDLE;
                end
            end
            S_HALT: begin
                w_stall  = 1'b1;
                w_run_en = 1'b0;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_hold       <= '0;
            r_display    <= 32'h0;
            r_disp_valid <= 1'b0;
            r_halted     <= 1'b0;
            r_count      <= SC_COUNT_RST;
        end else begin
            if (w_accept) begin
                if (r_count != CNT_MAX) begin
                    r_count <= r_count + 16'd1;
                end
                if (w_is_exit) begin
                    r_halted <= 1'b1;
                end else begin
                    r_display    <= sc_a0;
                    r_disp_valid <= 1'b1;
                    r_hold       <= HOLD_LOAD;
                end
            end else if ((r_state == S_SHOW) && !w_hold_zero) begin
                r_hold <= r_hold - HOLD_W'(1);
            end
        end
    end

    // Reset forces the pipeline to run and unstalled regardless of inputs.
    assign stall      = Resetn & w_stall;
    assign run_en     = ~Resetn | w_run_en;
    assign display    = r_display;
    assign disp_valid = r_disp_valid;
    assign halted     = r_halted;
    assign sc_count   = r_count;

endmodule

`default_nettype wire
